// File: rtl/idli_sqi_fetch_m.sv
// SQI sequential-read fetch engine: issues READ 0x03 + 24b address, then streams
// one 16b instruction word every four GCK cycles, aligned to the shared sync counter.
module idli_sqi_fetch_m (
   input  logic        i_sq_gck,
   input  logic        i_sq_rst_n,
   input  logic        i_sq_redir,
   input  logic [15:0] i_sq_redir_addr,
   output logic [1:0]  o_sq_ctr,
   output logic [15:0] o_sq_enc,
   output logic        o_sq_enc_vld,
   output logic        o_sq_cs_n,
   output logic [3:0]  o_sq_sio,
   output logic        o_sq_sio_oe,
   input  logic [3:0]  i_sq_sio
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        phase_q, phase_d;
   logic [1:0]        ctr_q;
   logic [15:0]       addr_q;
   logic [2:0][3:0]   nib_q;
   logic [23:0]       byte_addr;
   logic [3:0]        addr_nib;

   assign byte_addr = {7'b0, addr_q, 1'b0};

   always_ff @(posedge i_sq_gck or negedge i_sq_rst_n) begin
      if (!i_sq_rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= 3'd0;
         ctr_q   <= 2'd0;
         addr_q  <= 16'd0;
         nib_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         ctr_q   <= ctr_q + 2'd1;
         if (i_sq_redir)
            addr_q <= i_sq_redir_addr;
         // Nibble 3 is never stored: it is forwarded straight from the pins.
         if (state_q == ST_DATA) begin
            case (ctr_q)
               2'd0:    nib_q[0] <= i_sq_sio;
               2'd1:    nib_q[1] <= i_sq_sio;
               2'd2:    nib_q[2] <= i_sq_sio;
               default: nib_q    <= nib_q;
            endcase
         end
      end
   end

   always_comb begin
      addr_nib = 4'h0;
      case (phase_q)
         3'd0:    addr_nib = byte_addr[23:20];
         3'd1:    addr_nib = byte_addr[19:16];
         3'd2:    addr_nib = byte_addr[15:12];
         3'd3:    addr_nib = byte_addr[11:8];
         3'd4:    addr_nib = byte_addr[7:4];
         3'd5:    addr_nib = byte_addr[3:0];
         default: addr_nib = 4'h0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q + 3'd1;
      o_sq_cs_n   = 1'b1;
      o_sq_sio_oe = 1'b0;
      o_sq_sio    = 4'h0;
      case (state_q)
         ST_IDLE: begin
            phase_d = 3'd0;
            // Leaving at ctr==1 puts CMD at ctr==2, so the first data nibble lands on ctr==0.
            if (ctr_q == 2'd1)
               state_d = ST_CMD;
         end
         ST_CMD: begin
            o_sq_cs_n   = 1'b0;
            o_sq_sio_oe = 1'b1;
            o_sq_sio    = phase_q[0] ? 4'h3 : 4'h0;
            if (phase_q == 3'd1) begin
               state_d = ST_ADDR;
               phase_d = 3'd0;
            end
         end
         ST_ADDR: begin
            o_sq_cs_n   = 1'b0;
            o_sq_sio_oe = 1'b1;
            o_sq_sio    = addr_nib;
            if (phase_q == 3'd5) begin
               state_d = ST_DUMMY;
               phase_d = 3'd0;
            end
         end
         ST_DUMMY: begin
            o_sq_cs_n = 1'b0;
            if (phase_q == 3'd1) begin
               state_d = ST_DATA;
               phase_d = 3'd0;
            end
         end
         ST_DATA: begin
            o_sq_cs_n = 1'b0;
            phase_d   = 3'd0;
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = 3'd0;
         end
      endcase
      if (i_sq_redir) begin
         state_d = ST_IDLE;
         phase_d = 3'd0;
      end
   end

   assign o_sq_ctr     = ctr_q;
   assign o_sq_enc     = {i_sq_sio, nib_q[2], nib_q[1], nib_q[0]};
   assign o_sq_enc_vld = (state_q == ST_DATA) && (ctr_q == 2'd3) && !i_sq_redir;

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// Bench for idli_sqi_fetch_m: quad-SPI SRAM model driving the pins, a timeline model
// of the expected bus/output behaviour checked every cycle, plus literal spot checks.
module tb_idli_sqi_fetch_m;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redir = 1'b0;
   logic [15:0] redir_addr = 16'h0;
   logic [3:0]  sram_sio = 4'h0;
   logic [1:0]  ctr;
   logic [15:0] enc;
   logic        vld, cs_n, oe;
   logic [3:0]  sio;

   idli_sqi_fetch_m dut (
      .i_sq_gck        (clk),
      .i_sq_rst_n      (rst_n),
      .i_sq_redir      (redir),
      .i_sq_redir_addr (redir_addr),
      .o_sq_ctr        (ctr),
      .o_sq_enc        (enc),
      .o_sq_enc_vld    (vld),
      .o_sq_cs_n       (cs_n),
      .o_sq_sio        (sio),
      .o_sq_sio_oe     (oe),
      .i_sq_sio        (sram_sio)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   logic [15:0] mem [0:65535];

   // SRAM model: decodes command/address from the pins and streams nibbles, LS nibble first.
   int          s_idx = 0;
   logic [31:0] s_sh = 32'h0;
   always @(negedge clk) begin
      if (cs_n !== 1'b0) begin
         s_idx    = 0;
         sram_sio = 4'h0;
      end else begin
         if (s_idx < 8)
            s_sh = {s_sh[27:0], sio};
         if (s_idx >= 10) begin
            int j;
            logic [15:0] wd;
            j        = s_idx - 10;
            wd       = mem[16'((s_sh[23:0] >> 1) + 24'(j / 4))];
            sram_sio = 4'(wd >> (4 * (j % 4)));
         end else begin
            sram_sio = 4'h0;
         end
         s_idx++;
      end
   end

   // Cycle number since reset release.
   int c = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) c <= 0;
      else        c <= c + 1;
   end

   logic        lg_cs  [0:255];
   logic        lg_oe  [0:255];
   logic        lg_vld [0:255];
   logic [3:0]  lg_sio [0:255];
   logic [15:0] lg_enc [0:255];
   logic [1:0]  lg_ctr [0:255];

   // Timeline model: a fetch is idle or active since start cycle m_start; offsets give the bus phase.
   bit          m_act = 1'b0;
   int          m_start = 0;
   int          m_early = 1;
   logic [15:0] m_paddr = 16'h0;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            m_act   = 1'b0;
            m_early = 1;
            m_paddr = 16'h0;
         end else begin
            logic        e_cs, e_oe, e_vld;
            logic [3:0]  e_sio;
            logic [15:0] e_enc;
            int          off, pa;
            if (!m_act && c >= m_early && c % 4 == 2) begin
               m_act   = 1'b1;
               m_start = c;
            end
            e_cs = 1'b1; e_oe = 1'b0; e_sio = 4'h0; e_vld = 1'b0; e_enc = 16'h0;
            if (m_act) begin
               off  = c - m_start;
               pa   = int'(m_paddr);
               e_cs = 1'b0;
               if (off < 2) begin
                  e_oe  = 1'b1;
                  e_sio = (off == 1) ? 4'h3 : 4'h0;
               end else if (off < 8) begin
                  e_oe  = 1'b1;
                  e_sio = 4'(((pa * 2) >> (20 - 4 * (off - 2))) & 15);
               end else if (off >= 10 && (off - 10) % 4 == 3 && !redir) begin
                  e_vld = 1'b1;
                  e_enc = mem[16'(pa + (off - 10) / 4)];
               end
            end
            check("ctr", 32'(ctr), 32'(c % 4));
            check("cs_n", 32'(cs_n), 32'(e_cs));
            check("oe", 32'(oe), 32'(e_oe));
            check("sio", 32'(sio), 32'(e_sio));
            check("vld", 32'(vld), 32'(e_vld));
            if (e_vld)
               check("enc", 32'(enc), 32'(e_enc));
            if (c < 256) begin
               lg_cs[c] = cs_n; lg_oe[c] = oe; lg_vld[c] = vld;
               lg_sio[c] = sio; lg_enc[c] = enc; lg_ctr[c] = ctr;
            end
            if (redir) begin
               m_act   = 1'b0;
               m_early = c + 2;
               m_paddr = redir_addr;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      int k = 0;
      while (c != n && k < 300) begin
         tick();
         k++;
      end
      if (c != n)
         check("wait_cyc", 32'(c), 32'(n));
   endtask

   task automatic do_redir(input logic [15:0] a);
      redir      = 1'b1;
      redir_addr = a;
      tick();
      redir      = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic check_sio(input string nm, input int first, input logic [23:0] nibs);
      for (int i = 0; i < 6; i++)
         check(nm, 32'(lg_sio[first + i]), 32'(nibs[20 - 4 * i +: 4]));
   endtask

   initial begin
      int npulse;
      for (int i = 0; i < 65536; i++)
         mem[i] = 16'(i * 40503 + 7);
      mem[0]        = 16'h1234;
      mem[16'h0123] = 16'h0123;
      mem[16'h0010] = 16'hBEEF;

      // Reset values.
      tick(); tick(); tick();
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_oe", 32'(oe), 32'd0);
      check("rst_sio", 32'(sio), 32'd0);
      check("rst_vld", 32'(vld), 32'd0);
      check("rst_ctr", 32'(ctr), 32'd0);
      check("rst_enc", 32'(enc), 32'd0);
      rst_n = 1'b1;

      // Reset release: command/address sequence and first word.
      wait_cyc(17);
      check("rel_cs1", 32'(lg_cs[1]), 32'd1);
      check("rel_cs2", 32'(lg_cs[2]), 32'd0);
      check("rel_cmd0", 32'(lg_sio[2]), 32'h0);
      check("rel_cmd1", 32'(lg_sio[3]), 32'h3);
      check_sio("rel_addr", 4, 24'h000000);
      check("rel_oe9", 32'(lg_oe[9]), 32'd1);
      check("rel_oe10", 32'(lg_oe[10]), 32'd0);
      check("rel_oe11", 32'(lg_oe[11]), 32'd0);
      check("rel_vld15", 32'(lg_vld[15]), 32'd1);
      check("rel_ctr15", 32'(lg_ctr[15]), 32'd3);
      check("rel_enc15", 32'(lg_enc[15]), 32'h1234);

      // Streaming four words.
      mem[0] = 16'hA001; mem[1] = 16'hB002; mem[2] = 16'hC003; mem[3] = 16'hD004;
      do_reset();
      wait_cyc(29);
      check("str_w0", 32'(lg_enc[15]), 32'hA001);
      check("str_w1", 32'(lg_enc[19]), 32'hB002);
      check("str_w2", 32'(lg_enc[23]), 32'hC003);
      check("str_w3", 32'(lg_enc[27]), 32'hD004);
      npulse = 0;
      for (int i = 0; i < 29; i++)
         npulse += int'(lg_vld[i]);
      check("str_pulses", 32'(npulse), 32'd4);

      // Redirect in DATA on a ctr==3 cycle.
      wait_cyc(31);
      do_redir(16'h0123);
      wait_cyc(49);
      check("rd_vld31", 32'(lg_vld[31]), 32'd0);
      check("rd_cs32", 32'(lg_cs[32]), 32'd1);
      check("rd_cs34", 32'(lg_cs[34]), 32'd0);
      check_sio("rd_addr", 36, 24'h000246);
      check("rd_vld47", 32'(lg_vld[47]), 32'd1);
      check("rd_enc47", 32'(lg_enc[47]), 32'h0123);

      // Redirect mid-ADDR.
      do_reset();
      wait_cyc(6);
      do_redir(16'h0010);
      wait_cyc(25);
      check("ma_cs6", 32'(lg_cs[6]), 32'd0);
      check("ma_cs7", 32'(lg_cs[7]), 32'd1);
      check("ma_cs9", 32'(lg_cs[9]), 32'd1);
      check("ma_cs10", 32'(lg_cs[10]), 32'd0);
      check_sio("ma_addr", 12, 24'h000020);
      check("ma_enc23", 32'(lg_enc[23]), 32'hBEEF);

      // Back-to-back redirects.
      wait_cyc(30);
      do_redir(16'h0001);
      do_redir(16'h0002);
      wait_cyc(49);
      check("bb_cs31", 32'(lg_cs[31]), 32'd1);
      check("bb_cs33", 32'(lg_cs[33]), 32'd1);
      check("bb_cs34", 32'(lg_cs[34]), 32'd0);
      check_sio("bb_addr", 36, 24'h000004);
      check("bb_vld47", 32'(lg_vld[47]), 32'd1);
      check("bb_enc47", 32'(lg_enc[47]), 32'hC003);

      // Asynchronous reset during the nibble-2 cycle.
      wait_cyc(50);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_cs_n", 32'(cs_n), 32'd1);
      check("ar_oe", 32'(oe), 32'd0);
      check("ar_vld", 32'(vld), 32'd0);
      check("ar_ctr", 32'(ctr), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      wait_cyc(17);
      check_sio("ar_addr", 4, 24'h000000);
      check("ar_vld15", 32'(lg_vld[15]), 32'd1);
      check("ar_enc15", 32'(lg_enc[15]), 32'hA001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
